de0_nano_system_i2c_clk_arbiter: RTL and testbench
==================================================

# de0_nano_system_i2c_clk_arbiter

Avalon-MM slave that shares the single I2C clock-select resource and the I2C bus between two on-chip I2C requesters, such as the accelerometer engine and the EEPROM engine. It grants the bus round-robin, drives the clock-select line with the granted requester's configured rate, and inserts a programmable settle guard before each grant so the clock mux is stable. A hold timeout revokes a stuck grant and raises a sticky interrupt flag.

## Interface
- DEFAULT_GUARD, 16: reset value of GUARD register (settle cycles, 0..255)
- DEFAULT_TIMEOUT, 0: reset value of TIMEOUT register (0 = timeout disabled)
- clk  in  1  system clock; one clock domain
- reset_n  in  1  reset, synchronous, active-low
- address  in  2  register select
- chipselect  in  1  Avalon slave select
- write_n  in  1  write strobe, active-low
- writedata  in  32  write data
- readdata  out  32  combinational read mux of addressed register
- req  in  2  bus request per requester, level, held until done
- gnt  out  2  one-hot grant, registered
- sel_clk  out  1  I2C clock-rate select to the clock mux
- irq  out  1  equals sticky timeout flag

## Operation
- Register map. All unused bits read 0.
  - 0 CTRL (RW): [0] enable, [1] rate0 (sel_clk value for requester 0), [2] rate1. Reset 0.
  - 1 GUARD (RW): [7:0] settle cycles.
  - 2 STATUS: [1:0] gnt (RO), [2] settling (RO), [3] last_owner (RO), [4] timeout flag (RW1C).
  - 3 TIMEOUT (RW): [15:0] maximum grant length in cycles.
- Write = chipselect & ~write_n, taken on the clk edge; reads have no side effects.
- FSM states IDLE, SETTLE, GRANTED. Reset enters IDLE with gnt=0, sel_clk=0, last_owner=1, flag=0, CTRL=0, GUARD=DEFAULT_GUARD, TIMEOUT=DEFAULT_TIMEOUT.
- IDLE: if enable and req!=0, pick owner. With a single request, the requester wins. With both requesting, the winner is the requester != last_owner.
  - Load sel_clk with rate[owner] and load guard_cnt with GUARD, then go to SETTLE.
- SETTLE: if req[owner]=0, return to IDLE with no grant; last_owner is unchanged. Else if guard_cnt==0, go to GRANTED, set gnt[owner]=1, last_owner=owner, and clear hold_cnt. Else decrement guard_cnt.
- GRANTED: hold_cnt increments each cycle and saturates at 16 bits.
  - If req[owner]=0, drop gnt and go to IDLE.
  - Else if TIMEOUT!=0 and hold_cnt==TIMEOUT-1, drop gnt, set flag, and go to IDLE.
- sel_clk changes only on IDLE->SETTLE. It holds its value through GRANTED and IDLE. CTRL writes take effect at the next arbitration.
- Clearing enable blocks new arbitration only. SETTLE and GRANTED run to completion.
- Flag set and W1C in the same cycle: set wins.
- Synchronous reset mid-grant: gnt drops on that edge and the FSM enters IDLE.

## Timing
- req sampled high in IDLE at edge E: SETTLE from E, gnt high after edge E+GUARD+1. With GUARD=0, gnt rises one cycle after SETTLE is entered.
- sel_clk is stable GUARD+1 cycles before gnt rises.
- Release: req low sampled at edge R in GRANTED gives gnt low after R. The earliest next SETTLE entry is R+1, so there is at least 1 idle cycle between grants.
- Timeout: gnt stays high exactly TIMEOUT cycles, then drops. irq is high from that same edge.
- readdata is combinational, zero wait states. Register writes are visible on readdata the cycle after the write edge.

## Test plan
- Reset, GUARD=16, single request: assert req=01 with enable=1 and rate0=1. Required: sel_clk=1 after the next edge, gnt=01 exactly 17 cycles later. Drop req and gnt=00 after one edge.
- Contention / round-robin: req=11 held, each owner releases after 5 cycles and re-requests. Required: grants alternate 01,10,01,10. sel_clk follows rate0/rate1 with GUARD=0 and rate0=0, rate1=1.
- Withdraw during settle: GUARD=10, req0 pulsed 3 cycles. Required: no gnt, FSM returns to IDLE, last_owner unchanged.
- Timeout: TIMEOUT=100, req0 held forever. Required: gnt0 high exactly 100 cycles, irq=1, STATUS[4]=1.
  - Then write STATUS bit4=1: irq=0 next cycle.
  - With req0 still high, re-arbitration grants again.
- Enable/config change mid-grant: clear enable and flip rate0 during GRANTED. Required: grant continues and sel_clk is unchanged. After release, no new grant while enable=0.
- Sync reset mid-grant: reset_n low for one edge during GRANTED. Required: gnt=00 and sel_clk=0 on that edge, and all registers return to their reset values.

Source files
------------

// File: rtl/de0_nano_system_i2c_clk_arbiter.sv
// -----------------------------------------------------------------------------
// de0_nano_system_i2c_clk_arbiter
//
// Avalon-MM slave that shares the I2C bus and its single clock-select line
// between two on-chip I2C requesters. Grants are round-robin. Before each grant
// the clock-select line is loaded with the winner's configured rate and a
// programmable settle guard runs so the clock mux is stable by the time the
// grant rises. A hold timeout revokes a stuck grant and raises a sticky flag
// that doubles as the interrupt.
//
// Ports
//   clk         system clock (single domain)
//   reset_n     synchronous active-low reset
//   address     register select: 0 CTRL, 1 GUARD, 2 STATUS, 3 TIMEOUT
//   chipselect  Avalon slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    combinational read mux of the addressed register
//   req         per-requester bus request, level, held until done
//   gnt         registered one-hot grant
//   sel_clk     I2C clock-rate select to the clock mux
//   irq         sticky timeout flag
// -----------------------------------------------------------------------------
module de0_nano_system_i2c_clk_arbiter #(
  parameter logic [7:0]  DEFAULT_GUARD   = 8'd16,
  parameter logic [15:0] DEFAULT_TIMEOUT = 16'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic        sel_clk,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    GRANTED = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_GUARD   = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

  state_t      state;
  state_t      next_state;

  // Software-visible registers
  logic [2:0]  ctrl;        // [0] enable, [1] rate0, [2] rate1
  logic [7:0]  guard;
  logic [15:0] timeout;
  logic        flag;
  logic        last_owner;

  // Arbitration datapath
  logic        owner;       // requester currently settling or granted
  logic [7:0]  guard_cnt;
  logic [15:0] hold_cnt;

  // Decoded control
  logic        write_en;
  logic        pick;        // winner if arbitration happens this cycle
  logic        owner_req;   // current owner still requesting
  logic        timeout_hit;
  logic        start;
  logic        do_grant;
  logic        set_flag;
  logic        clear_flag;
  logic [1:0]  next_gnt;

  // Upper write-data bits are never stored.
  logic        unused_wdata;
  assign unused_wdata = ^writedata[31:16];

  assign write_en  = chipselect & ~write_n;
  assign owner_req = owner ? req[1] : req[0];

  // With both requesting, the one that did not hold the bus last wins;
  // otherwise the sole requester wins.
  assign pick = (req == 2'b11) ? ~last_owner : req[1];

  // hold_cnt is 0 on the first granted cycle, so matching TIMEOUT-1 drops the
  // grant after exactly TIMEOUT cycles high.
  assign timeout_hit = (state == GRANTED) && (timeout != 16'd0) &&
                       (hold_cnt == timeout - 16'd1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ctrl[0] && (req != 2'b00)) next_state = SETTLE;
      end
      SETTLE: begin
        if (!owner_req)               next_state = IDLE;
        else if (guard_cnt == 8'd0)   next_state = GRANTED;
      end
      GRANTED: begin
        if (!owner_req || timeout_hit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / strobe logic
  // ---------------------------------------------------------------------------
  always_comb begin
    start      = 1'b0;
    do_grant   = 1'b0;
    set_flag   = 1'b0;
    next_gnt   = 2'b00;
    clear_flag = write_en && (address == ADDR_STATUS) && writedata[4];
    case (state)
      IDLE:    start    = (next_state == SETTLE);
      SETTLE:  do_grant = (next_state == GRANTED);
      GRANTED: set_flag = owner_req && timeout_hit;
      default: ;
    endcase
    if (next_state == GRANTED) next_gnt = owner ? 2'b10 : 2'b01;
  end

  // ---------------------------------------------------------------------------
  // Registers and datapath
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous; every flop here is a plain register (no RAM),
  // so all of them are cleared on the reset edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl       <= 3'd0;
      guard      <= DEFAULT_GUARD;
      timeout    <= DEFAULT_TIMEOUT;
      flag       <= 1'b0;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      sel_clk    <= 1'b0;
      guard_cnt  <= 8'd0;
      hold_cnt   <= 16'd0;
      gnt        <= 2'b00;
    end else begin
      gnt <= next_gnt;

      // sel_clk only moves when a new arbitration starts, using the CTRL
      // value in force at that moment.
      if (start) begin
        owner     <= pick;
        sel_clk   <= pick ? ctrl[2] : ctrl[1];
        guard_cnt <= guard;
      end else if ((state == SETTLE) && (guard_cnt != 8'd0)) begin
        guard_cnt <= guard_cnt - 8'd1;
      end

      if (do_grant) begin
        last_owner <= owner;
        hold_cnt   <= 16'd0;
      end else if ((state == GRANTED) && (hold_cnt != 16'hFFFF)) begin
        hold_cnt <= hold_cnt + 16'd1;
      end

      if (write_en) begin
        case (address)
          ADDR_CTRL:    ctrl    <= writedata[2:0];
          ADDR_GUARD:   guard   <= writedata[7:0];
          ADDR_TIMEOUT: timeout <= writedata[15:0];
          default: ;
        endcase
      end

      // A timeout in the same cycle as a W1C keeps the flag set.
      if (set_flag)        flag <= 1'b1;
      else if (clear_flag) flag <= 1'b0;
    end
  end

  assign irq = flag;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:    readdata = {29'd0, ctrl};
      ADDR_GUARD:   readdata = {24'd0, guard};
      ADDR_STATUS:  readdata = {27'd0, flag, last_owner, (state == SETTLE), gnt};
      ADDR_TIMEOUT: readdata = {16'd0, timeout};
      default:      readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_de0_nano_system_i2c_clk_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for de0_nano_system_i2c_clk_arbiter.
//
// A driver applies directed scenarios followed by randomized traffic. For each
// cycle it predicts, from a transaction-level reference model, the outputs
// after the coming clock edge and pushes them into a queue; an independent
// monitor pops one entry per falling edge and compares gnt, sel_clk, irq and
// readdata.
//
// The reference model tracks the arbiter in terms of absolute edge numbers:
// when a requester wins, the edge at which its grant is due is computed
// directly (start edge + GUARD + 1), and a timeout is detected when the
// grant's age in edges reaches TIMEOUT.
// -----------------------------------------------------------------------------
module tb_de0_nano_system_i2c_clk_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        sel_clk;
  logic        irq;

  always #5 clk = ~clk;

  de0_nano_system_i2c_clk_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .req        (req),
    .gnt        (gnt),
    .sel_clk    (sel_clk),
    .irq        (irq)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  gnt;
    logic        sel;
    logic        irq;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @edge %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Monitor: one expectation per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("gnt",      e.cyc, {30'd0, gnt},     {30'd0, e.gnt});
        check("sel_clk",  e.cyc, {31'd0, sel_clk}, {31'd0, e.sel});
        check("irq",      e.cyc, {31'd0, irq},     {31'd0, e.irq});
        check("readdata", e.cyc, readdata,         e.rd);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [2:0]  m_ctrl      = 3'd0;
  logic [7:0]  m_guard     = 8'd16;
  logic [15:0] m_timeout   = 16'd0;
  logic        m_flag      = 1'b0;
  logic        m_last      = 1'b1;
  logic        m_sel       = 1'b0;
  logic        m_owner     = 1'b0;
  bit          m_active    = 1'b0;  // a requester is settling or granted
  bit          m_granted   = 1'b0;
  int          m_grant_at  = 0;     // edge at which the pending grant rises
  int          m_grant_start = 0;   // edge at which the current grant rose
  int          cyc         = 0;     // index of the edge being predicted

  function automatic logic [1:0] m_gnt();
    if (!m_granted) return 2'b00;
    return m_owner ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_ctrl};
      2'd1:    return {24'd0, m_guard};
      2'd2:    return {27'd0, m_flag, m_last, (m_active && !m_granted), m_gnt()};
      default: return {16'd0, m_timeout};
    endcase
  endfunction

  task automatic model_edge(input logic [1:0] r, input logic w, input logic [1:0] a,
                            input logic [31:0] d, input logic rn);
    bit timed_out = 1'b0;
    if (!rn) begin
      m_ctrl    = 3'd0;
      m_guard   = 8'd16;
      m_timeout = 16'd0;
      m_flag    = 1'b0;
      m_last    = 1'b1;
      m_sel     = 1'b0;
      m_active  = 1'b0;
      m_granted = 1'b0;
      cyc++;
      return;
    end
    if (m_active) begin
      if (!r[m_owner]) begin
        m_active  = 1'b0;
        m_granted = 1'b0;
      end else if (!m_granted) begin
        if (cyc == m_grant_at) begin
          m_granted     = 1'b1;
          m_last        = m_owner;
          m_grant_start = cyc;
        end
      end else if (m_timeout != 16'd0 && (cyc - m_grant_start) == int'(m_timeout)) begin
        m_active  = 1'b0;
        m_granted = 1'b0;
        timed_out = 1'b1;
      end
    end else if (m_ctrl[0] && r != 2'b00) begin
      m_owner    = (r == 2'b11) ? ~m_last : r[1];
      m_sel      = m_owner ? m_ctrl[2] : m_ctrl[1];
      m_active   = 1'b1;
      m_grant_at = cyc + int'(m_guard) + 1;
    end
    if (w) begin
      case (a)
        2'd0: m_ctrl    = d[2:0];
        2'd1: m_guard   = d[7:0];
        2'd2: if (d[4]) m_flag = 1'b0;
        default: m_timeout = d[15:0];
      endcase
    end
    if (timed_out) m_flag = 1'b1;
    cyc++;
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  logic [1:0] cur_req = 2'b00;

  // Called just after a falling edge; inputs stay put until the next one.
  task automatic cycle(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic rn);
    exp_t e;
    req       = cur_req;
    address   = a;
    writedata = d;
    reset_n   = rn;
    if (w) begin
      chipselect = 1'b1;
      write_n    = 1'b0;
    end else if ($urandom_range(0, 1) == 0) begin
      chipselect = 1'b0;
      write_n    = 1'($urandom_range(0, 1));
    end else begin
      chipselect = 1'b1;
      write_n    = 1'b1;
    end
    model_edge(cur_req, w, a, d, rn);
    e.gnt = m_gnt();
    e.sel = m_sel;
    e.irq = m_flag;
    e.rd  = m_rd(a);
    e.cyc = cyc - 1;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cycle(1'b1, a, d, 1'b1);
  endtask

  task automatic rd(input logic [1:0] a);
    cycle(1'b0, a, $urandom, 1'b1);
  endtask

  initial begin
    logic [1:0]  a;
    logic [31:0] d;

    // Reset
    cur_req = 2'b00;
    repeat (2) cycle(1'b0, 2'd0, 32'd0, 1'b0);
    rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);

    // Single request with the default 16-cycle guard, rate0 = 1
    wr(2'd0, 32'h0000_0003);
    cur_req = 2'b01;
    repeat (25) rd(2'd2);
    cur_req = 2'b00;
    repeat (3) rd(2'd2);

    // Contention, GUARD = 0, rate0 = 0, rate1 = 1; each owner releases after
    // five granted cycles and re-requests immediately.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h0000_0005);
    for (int i = 0; i < 60; i++) begin
      cur_req = 2'b11;
      if (m_granted && (cyc - m_grant_start) >= 5) cur_req[m_owner] = 1'b0;
      rd(2'd2);
    end
    cur_req = 2'b00;
    repeat (3) rd(2'd2);

    // Withdraw during settle
    wr(2'd1, 32'd10);
    cur_req = 2'b01;
    repeat (3) rd(2'd2);
    cur_req = 2'b00;
    repeat (15) rd(2'd2);

    // Timeout of 100 cycles, W1C of the flag, then re-arbitration
    wr(2'd1, 32'd0);
    wr(2'd3, 32'd100);
    cur_req = 2'b01;
    repeat (110) rd(2'd2);
    wr(2'd2, 32'h0000_0010);
    repeat (120) rd(2'd2);
    cur_req = 2'b00;
    repeat (2) rd(2'd2);
    wr(2'd2, 32'h0000_0010);
    wr(2'd3, 32'd0);

    // Clear enable and flip rate0 mid-grant
    wr(2'd0, 32'h0000_0003);
    cur_req = 2'b01;
    repeat (10) rd(2'd0);
    wr(2'd0, 32'h0000_0000);
    repeat (10) rd(2'd2);
    cur_req = 2'b00;
    repeat (2) rd(2'd2);
    cur_req = 2'b01;
    repeat (20) rd(2'd2);

    // Synchronous reset mid-grant
    wr(2'd0, 32'h0000_0003);
    wr(2'd1, 32'd4);
    wr(2'd3, 32'h0000_1234);
    repeat (10) rd(2'd2);
    cycle(1'b0, 2'd2, 32'd0, 1'b0);
    rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
    cur_req = 2'b00;

    // Randomized traffic
    wr(2'd0, 32'h0000_0007);
    wr(2'd1, 32'd2);
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 5) == 0) cur_req[b] = ~cur_req[b];
      if ($urandom_range(0, 399) == 0) begin
        cycle(1'b0, 2'($urandom_range(0, 3)), $urandom, 1'b0);
      end else if ($urandom_range(0, 7) == 0) begin
        a = 2'($urandom_range(0, 3));
        d = $urandom;
        case (a)
          2'd0: d[0] = ($urandom_range(0, 3) != 0);
          2'd1: d[7:0] = 8'($urandom_range(0, 6));
          2'd3: d[15:0] = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
          default: ;
        endcase
        cycle(1'b1, a, d, 1'b1);
      end else begin
        rd(2'($urandom_range(0, 3)));
      end
    end
    cur_req = 2'b00;
    repeat (3) rd(2'd2);

    // Every prediction must have been consumed by the monitor.
    check("scoreboard_drain", cyc, 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
